// File: rtl/banner_pkg.sv
// banner_pkg: banner geometry, scroller FSM states and column type
// shared by the banner scroller and its timer.
package banner_pkg;

  localparam int BANNER_LEN  = 129;
  localparam int BANNER_LAST = 128;
  localparam int BANNER_ROWS = 57;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_SWAP
  } scroll_state_t;

  typedef logic [BANNER_ROWS-1:0] banner_col_t;

  // base + inc modulo the banner length; inc never exceeds one lap
  function automatic logic [7:0] wrap_add(
    input logic [7:0] base,
    input logic [8:0] inc
  );
    logic [8:0] s;
    s = {1'b0, base} + inc;
    if (s >= 9'(BANNER_LEN)) s = s - 9'(BANNER_LEN);
    return s[7:0];
  endfunction

endpackage

// File: rtl/banner_tick_gen.sv
// banner_tick_gen: free-running scroll timer, frozen while en is low,
// with a one-cycle tick on terminal count.
module banner_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/banner_scroller.sv
// banner_scroller: fetches a COLS-wide banner window from ROM into a
// back buffer and swaps it to the display-facing front buffer per step.
module banner_scroller
  import banner_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int SCROLL_DIV = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [7:0]              rom_address,
  input  banner_col_t             rom_data,
  input  logic [$clog2(COLS)-1:0] col_idx,
  output banner_col_t             col_data,
  output logic [7:0]              offset,
  output logic                    frame_swap,
  output logic                    busy
);

  localparam int IW = $clog2(COLS);
  localparam logic [IW-1:0] K_LAST = IW'(COLS - 1);

  scroll_state_t r_state;
  logic [IW-1:0] r_k;
  logic [7:0]    r_offset;
  logic [7:0]    r_addr_hold;
  logic          r_pending;
  logic          r_swap;
  banner_col_t   r_back  [COLS];
  banner_col_t   r_front [COLS];

  logic       w_tick;
  logic       w_service;
  logic [7:0] w_addr;

  banner_tick_gen #(
    .DIV(SCROLL_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(w_tick)
  );

  assign w_addr    = wrap_add(r_offset, 9'(r_k));
  assign w_service = (r_state == S_IDLE) && r_pending;

  assign rom_address = (r_state == S_FETCH) ? w_addr : r_addr_hold;
  assign offset      = r_offset;
  assign frame_swap  = r_swap;
  assign busy        = !rst && (r_state != S_IDLE);

  always_comb begin
    col_data = '0;
    if ({1'b0, col_idx} < (IW+1)'(COLS)) begin
      col_data = r_front[col_idx];
    end
  end

  // ROM data lags its address by a cycle, so capture trails issue by one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_k         <= '0;
      r_offset    <= '0;
      r_addr_hold <= '0;
      r_pending   <= 1'b0;
      r_swap      <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        r_front[i] <= '0;
      end
    end else begin
      r_swap    <= 1'b0;
      r_pending <= w_tick || (r_pending && !w_service);
      unique case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_offset <= (r_offset == 8'(BANNER_LAST)) ?
                        '0 : r_offset + 8'd1;
            r_k      <= '0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_addr_hold <= w_addr;
          if (r_k != '0) begin
            r_back[r_k - 1'b1] <= rom_data;
          end
          r_k <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_back[COLS-1] <= rom_data;
          r_state        <= S_SWAP;
        end
        S_SWAP: begin
          r_front <= r_back;
          r_swap  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// tb_banner_scroller: random banner ROM, scoreboard of expected frames
// (offset, timing) checked by a monitor on every frame_swap.
module tb_banner_scroller;
  import banner_pkg::*;

  localparam int COLS = 16;
  localparam int DIV  = 4;

  typedef struct {
    int off;
    int due;
    int gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  rom_address;
  logic [7:0]  offset;
  banner_col_t rom_data;
  banner_col_t col_data;
  logic [3:0]  col_idx = '0;
  logic        frame_swap;
  logic        busy;

  banner_col_t rom [BANNER_LEN];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  banner_scroller #(
    .COLS      (COLS),
    .SCROLL_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .col_idx    (col_idx),
    .col_data   (col_data),
    .offset     (offset),
    .frame_swap (frame_swap),
    .busy       (busy)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rom_data <= (rom_address <= 8'd128) ? rom[rom_address] : '0;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // off < 0 means the whole window must read as zero
  task automatic sweep(input int off);
    int r;
    int idx;
    banner_col_t want;
    r = $urandom_range(0, COLS - 1);
    for (int i = 0; i < COLS; i++) begin
      idx = (r + i) % COLS;
      col_idx = idx[3:0];
      #1;
      want = (off < 0) ? '0 : rom[(off + idx) % BANNER_LEN];
      chk($sformatf("col%0d_off%0d", idx, off), 64'(col_data), 64'(want));
    end
  endtask

  task automatic push(input int off, input int due, input int gap);
    exp_t e;
    e.off = off;
    e.due = due;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", nm}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin : monitor
    exp_t e;
    bit   rst_hist;
    int   quiet;
    int   cur_off;
    int   last_swap;
    rst_hist  = 1'b0;
    quiet     = 0;
    cur_off   = 0;
    last_swap = 0;
    forever begin
      @(negedge clk);
      #5;
      if (rst) begin
        if (rst_hist) begin
          chk("rst_offset", 64'(offset), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_swap", 64'(frame_swap), 64'd0);
          sweep(-1);
        end
        rst_hist = 1'b1;
        quiet    = 0;
        cur_off  = 0;
      end else begin
        rst_hist = 1'b0;
        if (frame_swap) begin
          if (sb.size() == 0) begin
            chk("unexpected_swap", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("swap_offset", 64'(offset), 64'(e.off));
            chk("swap_busy", 64'(busy), 64'd0);
            if (e.due >= 0) chk("swap_cycle", 64'(cyc), 64'(e.due));
            if (e.gap >= 0) chk("swap_gap", 64'(cyc - last_swap), 64'(e.gap));
            sweep(e.off);
            cur_off = e.off;
          end
          last_swap = cyc;
          quiet     = 0;
        end else if (!en && !busy && sb.size() == 0) begin
          quiet++;
          if (quiet % 8 == 0) chk("hold_offset", 64'(offset), 64'(cur_off));
          if (quiet == 40) sweep(cur_off);
        end else begin
          quiet = 0;
        end
      end
    end
  end

  initial begin : stim
    int rel;
    int budget;
    logic [63:0] t;
    for (int a = 0; a < BANNER_LEN; a++) begin
      t = {$urandom(), $urandom()};
      rom[a] = t[56:0];
    end
    rom[0] = {3'b111, 54'd0};
    rom[3] = rom[3] | (57'h3F << 48);

    // power-on load of offset 0, independent of en
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    push(0, rel + 18, -1);
    wait_drain(60, "reset_load");

    // continuous stepping through the wrap point
    en = 1'b1;
    push(1, -1, -1);
    for (int s = 2; s <= 131; s++) push(s % BANNER_LEN, -1, 19);
    budget = 0;
    while (!(frame_swap && sb.size() == 2) && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    chk("stop_point", 64'(sb.size()), 64'd2);
    en = 1'b0;
    wait_drain(60, "last_step");

    // frozen timer
    repeat (45 + $urandom_range(0, 20)) @(negedge clk);

    // abort a fetch on its sixth cycle
    en = 1'b1;
    budget = 0;
    while (!busy && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("fetch_start", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    push(0, rel + 18, -1);
    wait_drain(60, "restart");

    en = 1'b1;
    push(1, -1, -1);
    for (int s = 2; s <= 6; s++) push(s, -1, 19);
    wait_drain(200, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
